// File: rtl/operand_sequencer8_pkg.sv
// Shared definitions for the ALU-stage sequencers: datapath width and FSM state encoding.
package operand_sequencer8_pkg;

  localparam int ALU_W = 8;

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_EXEC   = 2'd2,
    ST_RESULT = 2'd3
  } seq_state_e;

endpackage

// File: rtl/operand_sequencer8.sv
// Serial operand loader and result register wrapped around an external 8-bit logic unit.
// Handshakes: a transfer happens on a rising edge where valid && ready; ready/valid outputs depend only on state.
module operand_sequencer8
  import operand_sequencer8_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] lu_y,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic [7:0]       op_count,
  output logic [1:0]       dbg_state
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [7:0]       cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOAD_A;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    res_d     = res_q;
    zero_d    = zero_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      ST_LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_a_d  = in_data;
          state_d = ST_LOAD_B;
        end
      end
      ST_LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_b_d  = in_data;
          state_d = ST_EXEC;
        end
      end
      // Operands have been stable for a full cycle, so lu_y has settled.
      ST_EXEC: begin
        res_d   = lu_y;
        zero_d  = (lu_y == '0);
        state_d = ST_RESULT;
      end
      ST_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = ST_LOAD_A;
        end
      end
      default: state_d = ST_LOAD_A;
    endcase
  end

  assign busy      = (state_q != ST_LOAD_A);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign res_data  = res_q;
  assign res_zero  = zero_q;
  assign op_count  = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_operand_sequencer8.sv
// Bench for operand_sequencer8 with an AND unit as the logic-unit consumer.
module tb_operand_sequencer8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a, op_b, lu_y, res_data;
  logic       res_zero, res_valid, res_ready, busy;
  logic [7:0] op_count;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_cnt;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign lu_y = op_a & op_b;

  operand_sequencer8 dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .lu_y(lu_y), .res_data(res_data), .res_zero(res_zero),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .op_count(op_count),
    .dbg_state(dbg_state)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       zero;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("send_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input vec_t v);
    send_word(v.a);
    check("op_a_loaded", op_a, v.a);
    check("busy_load_b", busy, 1);
    send_word(v.b);
    check("op_b_loaded", op_b, v.b);
    check("exec_no_valid", res_valid, 0);
    check("exec_in_ready", in_ready, 0);
    step();
    check("res_valid_lat", res_valid, 1);
    check("res_data", res_data, v.y);
    check("res_zero", res_zero, v.zero);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    exp_cnt++;
    check("op_count", op_count, exp_cnt);
    check("idle_busy", busy, 0);
    check("op_a_retained", op_a, v.a);
  endtask

  task automatic run_stream(input int n_ops, input int pv, input int pr, input bit chk_period);
    int sent = 0, done = 0, cyc = 0, last = -1;
    logic [7:0] word, a_held, exp_y, got_y;
    logic got_z;
    bit have_a = 0, in_hs, out_hs;
    word = 8'($urandom_range(0, 255));
    while (done < n_ops && cyc < n_ops * 40 + 100) begin
      in_valid  = (sent < 2 * n_ops) && ($urandom_range(1, 100) <= pv);
      in_data   = word;
      res_ready = ($urandom_range(1, 100) <= pr);
      in_hs  = in_valid && in_ready;
      out_hs = res_valid && res_ready;
      got_y  = res_data;
      got_z  = res_zero;
      step();
      cyc++;
      if (in_hs) begin
        sent++;
        if (!have_a) begin
          a_held = word;
          have_a = 1;
        end else begin
          exp_q.push_back(a_held & word);
          have_a = 0;
        end
        word = 8'($urandom_range(0, 255));
      end
      if (out_hs) begin
        done++;
        check("exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          exp_y = exp_q.pop_front();
          check("stream_res_data", got_y, exp_y);
          check("stream_res_zero", got_z, exp_y == 8'h00);
        end
        exp_cnt++;
        check("stream_op_count", op_count, exp_cnt);
        if (chk_period && last >= 0) check("op_period", cyc - last, 4);
        last = cyc;
      end
    end
    in_valid  = 1'b0;
    res_ready = 1'b0;
    check("stream_done", done, n_ops);
    check("stream_leftover", exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{a: 8'hF0, b: 8'h3C, y: 8'h30, zero: 1'b0};
    vecs[1] = '{a: 8'hAA, b: 8'h55, y: 8'h00, zero: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, y: 8'hFF, zero: 1'b0};
    vecs[3] = '{a: 8'h00, b: 8'hFF, y: 8'h00, zero: 1'b1};
    vecs[4] = '{a: 8'h81, b: 8'hC3, y: 8'h81, zero: 1'b0};
    vecs[5] = '{a: 8'h01, b: 8'h01, y: 8'h01, zero: 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; res_ready = 1'b1;
    exp_cnt = 8'd0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_outputs", {op_a, op_b, res_data, res_zero, op_count}, 0);
    check("rst_state", dbg_state, 0);
    step();
    rst = 1'b0;
    // res_ready high while nothing is pending must not disturb anything
    step();
    check("idle_ready_noeffect", {busy, op_count}, 0);
    res_ready = 1'b0;

    for (int i = 0; i < 6; i++) run_op(vecs[i]);

    // Downstream stall with a word waiting upstream
    send_word(8'h3C);
    send_word(8'h0F);
    step();
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_frozen", {res_valid, in_ready, res_data, res_zero, op_a, op_b, op_count},
            {1'b1, 1'b0, 8'h0C, 1'b0, 8'h3C, 8'h0F, exp_cnt});
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    exp_cnt++;
    check("stall_accept_cnt", op_count, exp_cnt);
    step();
    in_valid = 1'b0;
    check("next_a_0x77", op_a, 8'h77);
    check("next_a_busy", busy, 1);

    // Reset in the middle of a pair
    send_word(8'h01);
    step();
    check("pair_77_01", res_data, 8'h01);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    exp_cnt++;
    send_word(8'h12);
    check("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_outs", {busy, in_ready, op_a, op_count}, {1'b0, 1'b1, 8'h00, 8'h00});
    step();
    #2 rst = 1'b0;
    exp_cnt = 8'd0;
    run_op('{a: 8'h0F, b: 8'hFF, y: 8'h0F, zero: 1'b0});

    run_stream(256, 100, 100, 1'b1);
    check("wrap_count", op_count, 8'd1);
    run_stream(1000, 60, 50, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
